// File: rtl/ifid_pipeline_if.sv
// ---------------------------------------------------------------------------
// ifid_pipeline_if
//
// Purpose : Bundles the IF->ID boundary signals of the 5-stage MIPS core.
//           The fetch side (and the hazard/branch logic) drive the request
//           group. The pipeline register drives the registered/decoded group.
//
// Signals :
//   opcode        fetched instruction word (IF)
//   pc_plus4      PC+4 of the fetched instruction
//   hazardflag    1 = hold the IF/ID register (stall)
//   flush         1 = replace the IF/ID contents with a bubble
//   ifidOpcode    registered instruction word
//   ifid_pc_plus4 registered PC+4
//   ifid_valid    1 = real instruction, 0 = bubble
//   id_*          MIPS field slices of ifidOpcode
//   stall_count   saturating count of stalled cycles since reset
//
// Handshake : there is no valid/ready pair on this boundary. The fetch side
//             presents opcode/pc_plus4 every cycle. The register accepts them
//             on a rising edge unless flush or hazardflag is high. A stalled
//             word is dropped, not queued; fetch must re-present it.
//
// Modports :
//   master  fetch/hazard side (drives inputs, observes outputs)
//   slave   the ifid_pipeline register itself
// ---------------------------------------------------------------------------
interface ifid_pipeline_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] opcode;
    logic [DATA_W-1:0] pc_plus4;
    logic              hazardflag;
    logic              flush;

    logic [DATA_W-1:0] ifidOpcode;
    logic [DATA_W-1:0] ifid_pc_plus4;
    logic              ifid_valid;
    logic [5:0]        id_op;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic [4:0]        id_shamt;
    logic [5:0]        id_funct;
    logic [15:0]       id_imm;
    logic [15:0]       stall_count;

    modport master (
        output opcode,
        output pc_plus4,
        output hazardflag,
        output flush,
        input  ifidOpcode,
        input  ifid_pc_plus4,
        input  ifid_valid,
        input  id_op,
        input  id_rs,
        input  id_rt,
        input  id_rd,
        input  id_shamt,
        input  id_funct,
        input  id_imm,
        input  stall_count
    );

    modport slave (
        input  opcode,
        input  pc_plus4,
        input  hazardflag,
        input  flush,
        output ifidOpcode,
        output ifid_pc_plus4,
        output ifid_valid,
        output id_op,
        output id_rs,
        output id_rt,
        output id_rd,
        output id_shamt,
        output id_funct,
        output id_imm,
        output stall_count
    );
endinterface

// File: rtl/ifid_pipeline.sv
// ---------------------------------------------------------------------------
// ifid_pipeline
//
// Purpose : IF/ID pipeline register of the 5-stage MIPS core. It captures the
//           fetched instruction and PC+4 on each rising clock edge. It holds
//           them while the hazard unit stalls, and loads a NOP bubble on a
//           branch/jump flush. It also presents pre-split MIPS fields to
//           decode, plus a valid bit and a saturating stall counter.
//
// Ports   :
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    ifid_pipeline_if.slave
//            in : opcode, pc_plus4, hazardflag, flush
//            out: ifidOpcode, ifid_pc_plus4, ifid_valid,
//                 id_op, id_rs, id_rt, id_rd, id_shamt, id_funct, id_imm,
//                 stall_count
//
// Update priority on each rising edge (after reset):
//   flush > hazardflag > normal load
//
// DATA_W must equal the DATA_W of the connected interface instance. The
// field slices assume a 32-bit MIPS instruction word.
// ---------------------------------------------------------------------------
module ifid_pipeline #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    ifid_pipeline_if.slave       bus
);

    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    // Registered state
    logic [DATA_W-1:0] instr_q;
    logic [DATA_W-1:0] pc4_q;
    logic              valid_q;
    logic [15:0]       stall_cnt_q;

    // Next-state selection
    logic [DATA_W-1:0] instr_d;
    logic [DATA_W-1:0] pc4_d;
    logic              valid_d;
    logic [15:0]       stall_cnt_d;

    always_comb begin
        instr_d     = instr_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;

        if (bus.flush) begin
            // The bubble wins even when a stall is also requested. A flushed
            // edge is not a stalled edge, so the counter does not move.
            instr_d = NOP_WORD;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (bus.hazardflag) begin
            // Hold everything; only the stall statistic advances. The
            // counter saturates rather than wrapping, so it never reads low
            // after a long stall.
            if (stall_cnt_q != STALL_MAX) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end else begin
            instr_d = bus.opcode;
            pc4_d   = bus.pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q     <= NOP_WORD;
            pc4_q       <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Outputs come only from registers. The field slices read the registered
    // word, so no input reaches decode combinationally.
    assign bus.ifidOpcode    = instr_q;
    assign bus.ifid_pc_plus4 = pc4_q;
    assign bus.ifid_valid    = valid_q;
    assign bus.stall_count   = stall_cnt_q;

    assign bus.id_op    = instr_q[31:26];
    assign bus.id_rs    = instr_q[25:21];
    assign bus.id_rt    = instr_q[20:16];
    assign bus.id_rd    = instr_q[15:11];
    assign bus.id_shamt = instr_q[10:6];
    assign bus.id_funct = instr_q[5:0];
    assign bus.id_imm   = instr_q[15:0];

endmodule

// File: tb/tb_ifid_pipeline.sv
// ---------------------------------------------------------------------------
// tb_ifid_pipeline
//
// Directed self-checking bench for ifid_pipeline. Inputs change 1 ns after a
// rising edge. Outputs are sampled at that same point, or mid-cycle for the
// asynchronous-reset checks.
// ---------------------------------------------------------------------------
module tb_ifid_pipeline;

    localparam int DATA_W = 32;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_pass   = 0;

    ifid_pipeline_if #(.DATA_W(DATA_W)) bus ();

    ifid_pipeline #(
        .DATA_W   (DATA_W),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] op, input logic [31:0] pc4,
                         input logic hz, input logic fl);
        bus.opcode     = op;
        bus.pc_plus4   = pc4;
        bus.hazardflag = hz;
        bus.flush      = fl;
    endtask

    initial begin
        reset = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        #12;

        // Reset state
        check("rst_opcode", bus.ifidOpcode, 32'h0);
        check("rst_pc4",    bus.ifid_pc_plus4, 32'h0);
        check("rst_valid",  {31'b0, bus.ifid_valid}, 32'h0);
        check("rst_cnt",    {16'b0, bus.stall_count}, 32'h0);

        reset = 1'b0;
        tick();

        // Normal pass-through: add $8,$9,$10
        drive(32'h012A4020, 32'h4, 1'b0, 1'b0);
        #1;
        check("no_comb_path", bus.ifidOpcode, 32'h0);
        tick();
        check("pass_opcode", bus.ifidOpcode, 32'h012A4020);
        check("pass_pc4",    bus.ifid_pc_plus4, 32'h4);
        check("pass_valid",  {31'b0, bus.ifid_valid}, 32'h1);
        check("pass_op",     {26'b0, bus.id_op}, 32'h0);
        check("pass_rs",     {27'b0, bus.id_rs}, 32'd9);
        check("pass_rt",     {27'b0, bus.id_rt}, 32'd10);
        check("pass_rd",     {27'b0, bus.id_rd}, 32'd8);
        check("pass_shamt",  {27'b0, bus.id_shamt}, 32'd0);
        check("pass_funct",  {26'b0, bus.id_funct}, 32'h20);

        // Stall: load lw, then hold for 3 edges while sw is presented
        drive(32'h8C220004, 32'h8, 1'b0, 1'b0);
        tick();
        check("stall_load", bus.ifidOpcode, 32'h8C220004);
        drive(32'hAC230008, 32'hC, 1'b1, 1'b0);
        tick();
        check("stall_cnt1", {16'b0, bus.stall_count}, 32'd1);
        tick();
        tick();
        check("stall_hold_op",  bus.ifidOpcode, 32'h8C220004);
        check("stall_hold_pc4", bus.ifid_pc_plus4, 32'h8);
        check("stall_hold_vld", {31'b0, bus.ifid_valid}, 32'h1);
        check("stall_cnt3",     {16'b0, bus.stall_count}, 32'd3);
        drive(32'hAC230008, 32'hC, 1'b0, 1'b0);
        tick();
        check("stall_release_op",  bus.ifidOpcode, 32'hAC230008);
        check("stall_release_pc4", bus.ifid_pc_plus4, 32'hC);
        check("stall_release_cnt", {16'b0, bus.stall_count}, 32'd3);

        // Flush beats stall
        drive(32'h10220003, 32'h10, 1'b0, 1'b0);
        tick();
        check("flush_pre", bus.ifidOpcode, 32'h10220003);
        drive(32'h12345678, 32'h14, 1'b1, 1'b1);
        tick();
        check("flush_op",    bus.ifidOpcode, 32'h0);
        check("flush_pc4",   bus.ifid_pc_plus4, 32'h0);
        check("flush_valid", {31'b0, bus.ifid_valid}, 32'h0);
        check("flush_cnt",   {16'b0, bus.stall_count}, 32'd3);

        // Stall while holding a bubble keeps the bubble
        drive(32'h12345678, 32'h14, 1'b1, 1'b0);
        tick();
        check("bubble_hold_vld", {31'b0, bus.ifid_valid}, 32'h0);
        check("bubble_hold_cnt", {16'b0, bus.stall_count}, 32'd4);

        // Immediate decode: addi $8,$9,-1
        drive(32'h2128FFFF, 32'h18, 1'b0, 1'b0);
        tick();
        check("imm_op",  {26'b0, bus.id_op}, 32'h08);
        check("imm_rs",  {27'b0, bus.id_rs}, 32'd9);
        check("imm_rt",  {27'b0, bus.id_rt}, 32'd8);
        check("imm_imm", {16'b0, bus.id_imm}, 32'h0000FFFF);

        // Asynchronous reset mid-cycle, mid-stall, with lw loaded
        drive(32'h8C220004, 32'h1C, 1'b0, 1'b0);
        tick();
        check("arst_pre", bus.ifidOpcode, 32'h8C220004);
        drive(32'h8C220004, 32'h1C, 1'b1, 1'b0);
        tick();
        check("arst_pre_cnt", {16'b0, bus.stall_count}, 32'd5);
        #3;
        reset = 1'b1;
        #1;
        check("arst_opcode", bus.ifidOpcode, 32'h0);
        check("arst_pc4",    bus.ifid_pc_plus4, 32'h0);
        check("arst_valid",  {31'b0, bus.ifid_valid}, 32'h0);
        check("arst_cnt",    {16'b0, bus.stall_count}, 32'h0);
        #2;
        reset = 1'b0;

        // Saturation: hazardflag is still high from the previous step
        repeat (65534) tick();
        check("sat_fffe", {16'b0, bus.stall_count}, 32'h0000FFFE);
        tick();
        check("sat_ffff", {16'b0, bus.stall_count}, 32'h0000FFFF);
        repeat (5) tick();
        check("sat_stays", {16'b0, bus.stall_count}, 32'h0000FFFF);
        check("sat_hold_op", bus.ifidOpcode, 32'h0);
        drive(32'h8C220004, 32'h20, 1'b0, 1'b0);
        tick();
        check("sat_load_op", bus.ifidOpcode, 32'h8C220004);
        check("sat_load_cnt", {16'b0, bus.stall_count}, 32'h0000FFFF);

        // Reset is the only thing that clears the counter
        #3;
        reset = 1'b1;
        #1;
        check("sat_reset_cnt", {16'b0, bus.stall_count}, 32'h0);
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ifid_pipeline.md
Name: ifid_pipeline

Overview:
- IF/ID pipeline register of the 5-stage MIPS core; sits between instruction fetch and decode.
- Captures the fetched instruction word and PC+4 each clock.
- Holds its contents when the hazard unit asserts a stall; inserts a NOP bubble on flush.
- Provides pre-split MIPS instruction fields and a valid bit to the decode stage.

Parameters:
- DATA_W, 32, width of instruction word and PC.
- NOP_WORD, 32'h0000_0000, value loaded on reset or flush (sll $0,$0,0).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  DATA_W  instruction word fetched in IF.
- pc_plus4  in  DATA_W  PC+4 of the fetched instruction.
- hazardflag  in  1  stall request from hazard unit; 1 = hold register.
- flush  in  1  branch/jump flush; 1 = load bubble.
- ifidOpcode  out  DATA_W  registered instruction word.
- ifid_pc_plus4  out  DATA_W  registered PC+4.
- ifid_valid  out  1  1 = register holds a real instruction, 0 = bubble.
- id_op  out  6  ifidOpcode[31:26].
- id_rs  out  5  ifidOpcode[25:21].
- id_rt  out  5  ifidOpcode[20:16].
- id_rd  out  5  ifidOpcode[15:11].
- id_shamt  out  5  ifidOpcode[10:6].
- id_funct  out  6  ifidOpcode[5:0].
- id_imm  out  16  ifidOpcode[15:0].
- stall_count  out  16  number of cycles held by hazardflag since reset; saturates at 16'hFFFF.

Behaviour:
- Reset is asynchronous: while reset=1, independent of clk:
  - ifidOpcode=NOP_WORD, ifid_pc_plus4=0, ifid_valid=0, stall_count=0.
  - Reset takes effect immediately even mid-stall or mid-flush.
- All other state updates on the rising edge of clk only. Priority per edge:
  1. flush=1: ifidOpcode=NOP_WORD, ifid_pc_plus4=0, ifid_valid=0. Flush wins over hazardflag.
  2. else hazardflag=1: all registered outputs keep their previous values; stall_count increments unless already 16'hFFFF.
  3. else: ifidOpcode<=opcode, ifid_pc_plus4<=pc_plus4, ifid_valid<=1.
- Latency: one cycle from opcode to ifidOpcode; zero-cycle combinational path is forbidden.
- Field outputs (id_*) are pure combinational slices of the registered ifidOpcode. No path from inputs to the field outputs.
- Consecutive stalls hold the value indefinitely; the first non-stall edge loads the opcode present at that edge. Instructions presented during the stall are not queued.
- stall_count:
  - Increments only on edges where hazardflag=1 and flush=0.
  - Does not wrap.
  - Cleared only by reset.
- X on hazardflag/flush is a verification error; no defined response.

Test Plan:
- Reset: assert reset asynchronously between edges with register loaded with 32'h8C220004 → ifidOpcode=0, ifid_valid=0, stall_count=0 immediately, before the next clk edge.
- Normal pass-through: hazardflag=0, opcode=32'h012A4020, pc_plus4=32'h4 → after one edge ifidOpcode=32'h012A4020, ifid_valid=1, id_op=0, id_rs=9, id_rt=10, id_rd=8, id_funct=6'h20.
- Stall:
  - Load 32'h8C220004, then hazardflag=1 for 3 edges while opcode=32'hAC230008.
  - Expect ifidOpcode stays 32'h8C220004, stall_count=3.
  - Release hazardflag → next edge ifidOpcode=32'hAC230008.
- Flush beats stall: register holds 32'h10220003; flush=1 and hazardflag=1 on the same edge → ifidOpcode=0, ifid_valid=0, stall_count unchanged.
- Immediate decode: ifidOpcode=32'h2128FFFF → id_op=6'h08, id_rs=9, id_rt=8, id_imm=16'hFFFF.
- Saturation: force 65540 consecutive stall cycles → stall_count=16'hFFFF and stays there.
